regfile_wb_arbiter: RTL and testbench

//   Writeback stage directly upstream of the CPU register bank list.

---
 rtl/regfile_wb_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_fifo.sv | 67 ++++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and width helpers for the register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int WB_REG_NUM    = 32;
    localparam int WB_DATA_WIDTH = 64;

    function automatic int addr_width(input int reg_num);
        return (reg_num > 1) ? $clog2(reg_num) : 1;
    endfunction

    localparam int WB_AW = addr_width(WB_REG_NUM);

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [WB_AW-1:0]         addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO with per-slot valid bits; the tag field (top TAG_W
// bits of each entry) is exported so the owner can see every queued entry.
module wb_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [DEPTH*TAG_W-1:0] tags,
    output logic [DEPTH-1:0]       valid
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;

    always_comb begin
        valid_next = valid_reg;
        if (pop) valid_next[rd_ptr_reg] = 1'b0;
        if (push) valid_next[wr_ptr_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            valid_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            valid_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by valid_reg.
    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg] <= din;
    end

    assign full  = &valid_reg;
    assign empty = ~|valid_reg;
    assign head  = mem_reg[rd_ptr_reg];
    assign valid = valid_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tags
            assign tags[gi*TAG_W +: TAG_W] = mem_reg[gi][WIDTH-1 -: TAG_W];
        end
    endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit register writes into one
// registered write per cycle, with a pending-write mask for hazard stalls.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int REG_NUM    = WB_REG_NUM,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 2,
    localparam int AW        = addr_width(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [AW-1:0]         alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [AW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  flush,
    output logic [AW-1:0]         write_addr_cpu,
    output logic [DATA_WIDTH-1:0] data_in_cpu,
    output logic                  write_en_cpu,
    output logic [REG_NUM-1:0]    pending_mask,
    output logic                  idle
);

    localparam int EW = AW + DATA_WIDTH;

    logic                    alu_push, mem_push;
    logic                    alu_full, alu_empty, mem_full, mem_empty;
    logic                    grant_alu, grant_mem;
    logic [EW-1:0]           alu_head, mem_head;
    logic [FIFO_DEPTH*AW-1:0] alu_tags, mem_tags;
    logic [FIFO_DEPTH-1:0]   alu_valid_vec, mem_valid_vec;
    wb_src_e                 prio_reg;
    logic                    we_reg;
    logic [AW-1:0]           addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [REG_NUM-1:0]      mask_comb;

    // Ready is held high during reset; captures are blocked by gating push.
    assign alu_ready = !reset || (!alu_full && !flush);
    assign mem_ready = !reset || (!mem_full && !flush);
    assign alu_push  = reset && alu_valid && alu_ready && (alu_addr != '0);
    assign mem_push  = reset && mem_valid && mem_ready && (mem_addr != '0);

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .TAG_W(AW)) u_alu_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (alu_push),
        .pop   (grant_alu),
        .flush (flush),
        .din   ({alu_addr, alu_data}),
        .full  (alu_full),
        .empty (alu_empty),
        .head  (alu_head),
        .tags  (alu_tags),
        .valid (alu_valid_vec)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .TAG_W(AW)) u_mem_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (mem_push),
        .pop   (grant_mem),
        .flush (flush),
        .din   ({mem_addr, mem_data}),
        .full  (mem_full),
        .empty (mem_empty),
        .head  (mem_head),
        .tags  (mem_tags),
        .valid (mem_valid_vec)
    );

    // prio_reg names the source that wins when both heads are waiting.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!flush) begin
            if (!alu_empty && !mem_empty) begin
                if (prio_reg == WB_SRC_ALU) grant_alu = 1'b1;
                else                        grant_mem = 1'b1;
            end else if (!alu_empty) begin
                grant_alu = 1'b1;
            end else if (!mem_empty) begin
                grant_mem = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_reg <= WB_SRC_ALU;
            we_reg   <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
        end else begin
            we_reg <= grant_alu || grant_mem;
            if (grant_alu) begin
                {addr_reg, data_reg} <= alu_head;
                prio_reg             <= WB_SRC_MEM;
            end else if (grant_mem) begin
                {addr_reg, data_reg} <= mem_head;
                prio_reg             <= WB_SRC_ALU;
            end
        end
    end

    always_comb begin
        mask_comb = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_valid_vec[i]) mask_comb[alu_tags[i*AW +: AW]] = 1'b1;
            if (mem_valid_vec[i]) mask_comb[mem_tags[i*AW +: AW]] = 1'b1;
        end
        if (we_reg) mask_comb[addr_reg] = 1'b1;
        mask_comb[0] = 1'b0;
    end

    assign write_en_cpu   = we_reg;
    assign write_addr_cpu = addr_reg;
    assign data_in_cpu    = data_reg;
    assign pending_mask   = mask_comb;
    assign idle           = alu_empty && mem_empty && !we_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a queue-based
// transaction model of the two writeback sources.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int REG_NUM = 32;
    localparam int DW      = 64;
    localparam int DEPTH   = 2;
    localparam int AW      = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               alu_valid, mem_valid, flush;
    logic [AW-1:0]      alu_addr, mem_addr;
    logic [DW-1:0]      alu_data, mem_data;
    logic               alu_ready, mem_ready, write_en_cpu, idle;
    logic [AW-1:0]      write_addr_cpu;
    logic [DW-1:0]      data_in_cpu;
    logic [REG_NUM-1:0] pending_mask;

    int total = 0;
    int bad   = 0;

    wb_req_t       alu_q[$];
    wb_req_t       mem_q[$];
    wb_src_e       m_prio;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            acc_a, acc_m;
    int            hs_cnt, wr_seen, alu_low, mem_low;
    logic [AW-1:0] wlog[$];

    regfile_wb_arbiter #(.REG_NUM(REG_NUM), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .flush          (flush),
        .write_addr_cpu (write_addr_cpu),
        .data_in_cpu    (data_in_cpu),
        .write_en_cpu   (write_en_cpu),
        .pending_mask   (pending_mask),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        alu_q.delete();
        mem_q.delete();
        m_prio = WB_SRC_ALU;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    function automatic logic [REG_NUM-1:0] exp_mask();
        logic [REG_NUM-1:0] m;
        m = '0;
        foreach (alu_q[i]) m[alu_q[i].addr] = 1'b1;
        foreach (mem_q[i]) m[mem_q[i].addr] = 1'b1;
        if (m_we) m[m_addr] = 1'b1;
        return m;
    endfunction

    task automatic check_outputs();
        logic ra, rm;
        ra = !reset || ((alu_q.size() < DEPTH) && !flush);
        rm = !reset || ((mem_q.size() < DEPTH) && !flush);
        chk("alu_ready", alu_ready, ra);
        chk("mem_ready", mem_ready, rm);
        chk("write_en", write_en_cpu, m_we);
        if (m_we) begin
            chk("write_addr", write_addr_cpu, m_addr);
            chk("write_data", data_in_cpu, m_data);
        end
        chk("pending_mask", pending_mask, exp_mask());
        chk("idle", idle, (alu_q.size() == 0) && (mem_q.size() == 0) && !m_we);
        if (alu_ready !== 1'b1) alu_low++;
        if (mem_ready !== 1'b1) mem_low++;
        if (write_en_cpu === 1'b1) begin
            wr_seen++;
            wlog.push_back(write_addr_cpu);
        end
    endtask

    // One clock edge of the reference: at most one write leaves, the source
    // not served last wins a tie, flush discards everything still queued.
    task automatic model_edge();
        wb_req_t r;
        bit      take_alu, take_mem;
        if (!reset) begin
            model_reset();
            acc_a = 1'b0;
            acc_m = 1'b0;
            return;
        end
        acc_a = alu_valid && (alu_q.size() < DEPTH) && !flush;
        acc_m = mem_valid && (mem_q.size() < DEPTH) && !flush;
        take_alu = !flush && (alu_q.size() > 0) && ((mem_q.size() == 0) || (m_prio == WB_SRC_ALU));
        take_mem = !flush && (mem_q.size() > 0) && !take_alu;
        m_we = take_alu || take_mem;
        if (take_alu) begin
            r = alu_q.pop_front();
            m_addr = r.addr;
            m_data = r.data;
            m_prio = WB_SRC_MEM;
        end else if (take_mem) begin
            r = mem_q.pop_front();
            m_addr = r.addr;
            m_data = r.data;
            m_prio = WB_SRC_ALU;
        end
        if (flush) begin
            alu_q.delete();
            mem_q.delete();
        end
        if (acc_a && alu_addr != '0) begin
            r.addr = alu_addr;
            r.data = alu_data;
            alu_q.push_back(r);
            hs_cnt++;
        end
        if (acc_m && mem_addr != '0) begin
            r.addr = mem_addr;
            r.data = mem_data;
            mem_q.push_back(r);
            hs_cnt++;
        end
        foreach (alu_q[i]) foreach (mem_q[j])
            assert (alu_q[i].addr != mem_q[j].addr) else begin
                bad++;
                $error("FAIL hazard observed=0x%0h expected=distinct", alu_q[i].addr);
            end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [AW-1:0] alu_list [3];
        logic [AW-1:0] mem_list [3];
        logic [AW-1:0] exp3 [6];
        int ai, mi, w0, h0, r;

        alu_list = '{5'd1, 5'd2, 5'd3};
        mem_list = '{5'd17, 5'd18, 5'd19};
        exp3     = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19};

        reset = 1'b0; flush = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        hs_cnt = 0; wr_seen = 0; alu_low = 0; mem_low = 0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Async reset in the middle of a burst.
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1'b1; alu_addr = AW'($urandom_range(1, 15));  alu_data = {$urandom, $urandom};
            mem_valid = 1'b1; mem_addr = AW'($urandom_range(16, 31)); mem_data = {$urandom, $urandom};
            tick();
        end
        #2 reset = 1'b0;
        #1;
        chk("rst_we", write_en_cpu, 1'b0);
        chk("rst_addr", write_addr_cpu, '0);
        chk("rst_data", data_in_cpu, '0);
        chk("rst_mask", pending_mask, '0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_mem_ready", mem_ready, 1'b1);
        model_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rel_alu_ready", alu_ready, 1'b1);
        chk("rel_mem_ready", mem_ready, 1'b1);
        chk("rel_mask", pending_mask, '0);
        chk("rel_idle", idle, 1'b1);
        tick();

        // Both sources at once, alternating from ALU after reset.
        do_reset();
        wlog.delete();
        ai = 0; mi = 0;
        for (int c = 0; c < 20; c++) begin
            alu_valid = (ai < 3);
            if (ai < 3) begin alu_addr = alu_list[ai]; alu_data = 64'hA000 + DW'(ai); end
            mem_valid = (mi < 3);
            if (mi < 3) begin mem_addr = mem_list[mi]; mem_data = 64'hB000 + DW'(mi); end
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("t3_count", wlog.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < wlog.size()) chk($sformatf("t3_order%0d", k), wlog[k], exp3[k]);

        // Single ALU write: two-cycle latency, one-cycle strobe.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'hDEAD;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("t2_c1_we", write_en_cpu, 1'b0);
        chk("t2_c1_pm5", pending_mask[5], 1'b1);
        tick();
        #1;
        chk("t2_c2_we", write_en_cpu, 1'b1);
        chk("t2_c2_addr", write_addr_cpu, 5'd5);
        chk("t2_c2_data", data_in_cpu, 64'hDEAD);
        chk("t2_c2_pm5", pending_mask[5], 1'b1);
        tick();
        #1;
        chk("t2_c3_we", write_en_cpu, 1'b0);
        chk("t2_c3_pm5", pending_mask[5], 1'b0);
        tick();

        // Writes to x0 are swallowed.
        w0 = wr_seen;
        alu_valid = 1'b1; alu_addr = '0; alu_data = 64'hFFFF;
        tick();
        alu_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #1;
        chk("t5_no_write", wr_seen - w0, 0);
        chk("t5_mask", pending_mask, '0);
        chk("t5_idle", idle, 1'b1);

        // Sustained traffic from both sources fills both FIFOs.
        alu_low = 0; mem_low = 0; h0 = hs_cnt; w0 = wr_seen;
        for (int c = 0; c < 10; c++) begin
            alu_valid = 1'b1; alu_addr = AW'($urandom_range(1, 15));  alu_data = {$urandom, $urandom};
            mem_valid = 1'b1; mem_addr = AW'($urandom_range(16, 31)); mem_data = {$urandom, $urandom};
            tick();
        end
        chk("t4_alu_ready_dropped", alu_low > 0, 1'b1);
        chk("t4_mem_ready_dropped", mem_low > 0, 1'b1);
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("t4_writes_eq_handshakes", wr_seen - w0, hs_cnt - h0);

        // Flush with one write on the port and two ALU entries queued.
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 64'h6;
        mem_valid = 1'b1; mem_addr = 5'd20; mem_data = 64'h20;
        tick();
        alu_addr = 5'd7; alu_data = 64'h7;
        mem_addr = 5'd21; mem_data = 64'h21;
        tick();
        alu_addr = 5'd8; alu_data = 64'h8;
        mem_valid = 1'b0;
        tick();
        alu_valid = 1'b0;
        flush = 1'b1;
        w0 = wr_seen;
        #1;
        chk("t6_port_we", write_en_cpu, 1'b1);
        chk("t6_port_addr", write_addr_cpu, 5'd20);
        chk("t6_alu_full", alu_q.size(), 2);
        tick();
        flush = 1'b0;
        #1;
        chk("t6_after_we", write_en_cpu, 1'b0);
        chk("t6_after_idle", idle, 1'b1);
        for (int c = 0; c < 4; c++) tick();
        chk("t6_writes", wr_seen - w0, 1);

        // Randomized traffic with occasional flush and one async reset.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                reset = 1'b0;
                #1;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            flush     = ($urandom_range(0, 24) == 0);
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_addr  = AW'($urandom_range(0, 15));
            alu_data  = {$urandom, $urandom};
            mem_valid = ($urandom_range(0, 9) < 6);
            r         = $urandom_range(15, 31);
            mem_addr  = (r == 15) ? '0 : AW'(r);
            mem_data  = {$urandom, $urandom};
            tick();
        end
        reset = 1'b1; flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        #1;
        chk("final_idle", idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
